dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single data-memory port between two requesters: port 0 is the load/store path from the memory stage, and port 1 is a secondary master (debug or DMA).
- Provides round-robin arbitration and a registered request hold.
- Allows one outstanding transaction, routes the response back to its owner, and times out a response that never arrives.
- Sits between the pipeline memory stage and data memory.
- Out of scope, handled upstream: access-size legality, alignment checks and bounds checks.

Parameters:
TIMEOUT_CYCLES, 64, cycles allowed from entering REQ until mem_rvalid_i; 0 disables the timeout.

Ports:
clk  input  1  clock, rising edge
resetn  input  1  asynchronous active-low reset
req0_i  input  1  port 0 request
addr0_i  input  64  port 0 address
byte_en0_i  input  2  port 0 access size (BYTE/HALF_WORD/WORD/DOUBLE_WORD encoding)
wr0_i  input  1  port 0 write
wr_data0_i  input  64  port 0 write data
gnt0_o  output  1  port 0 request captured this cycle
rvalid0_o  output  1  port 0 response valid
rdata0_o  output  64  port 0 read data
err0_o  output  1  port 0 timeout error, qualifies rvalid0_o
req1_i, addr1_i, byte_en1_i, wr1_i, wr_data1_i, gnt1_o, rvalid1_o, rdata1_o, err1_o: same as port 0
mem_req_o  output  1  memory request
mem_addr_o  output  64  memory address
mem_byte_en_o  output  2  memory access size
mem_wr_o  output  1  memory write
mem_wr_data_o  output  64  memory write data
mem_gnt_i  input  1  memory accepted request
mem_rvalid_i  input  1  memory response, including write ack
mem_rdata_i  input  64  memory read data
busy_o  output  1  state != IDLE

Behaviour:
- States are IDLE, REQ and RSP. Reset is asynchronous active-low via resetn; on reset:
  - state = IDLE, owner = 0, last_winner = 1 (port 0 wins the first contention), timeout counter = 0.
  - Captured request registers = 0, so all outputs are 0.
- IDLE:
  - Winner selection:
    - Only one of req0_i/req1_i set: that port wins.
    - Both set: the port != last_winner wins.
  - On the winning cycle, gntN_o = 1 combinationally for the winner only.
  - At the clock edge, addr/byte_en/wr/wr_data are captured, owner and last_winner are set to the winner, counter is cleared, and state moves to REQ.
  - The loser's request is ignored; the requester must hold it until granted.
- REQ:
  - mem_req_o = 1, driven from the captured registers; mem_* outputs stay stable until mem_gnt_i.
  - mem_gnt_i = 1 moves state to RSP.
  - mem_req_o = 0 in every state other than REQ; mem_addr_o etc. keep their captured values.
- RSP:
  - rvalidN_o = mem_rvalid_i for N = owner, and 0 for the other port.
  - rdataN_o = mem_rdata_i for the owner, and 0 for the other port.
  - mem_rvalid_i returns state to IDLE.
  - A response that coincides with the memory grant is not allowed: a response is accepted only in RSP.
- Timeout:
  - The counter increments each cycle in REQ and RSP.
  - If TIMEOUT_CYCLES != 0, the counter reaches TIMEOUT_CYCLES and mem_rvalid_i = 0: the owner gets rvalidN_o = 1, errN_o = 1 and rdataN_o = 0 for one cycle, and state returns to IDLE.
  - If the timeout fires in REQ, mem_req_o drops.
  - The counter width holds TIMEOUT_CYCLES without wrap.
  - If rvalid and the timeout coincide, rvalid wins and err = 0.
- Stray rvalid: mem_rvalid_i in IDLE or REQ is dropped; no rvalidN_o is raised.
- Latency and throughput:
  - Minimum request-to-response path: grant in cycle 0, mem_req_o in cycle 1, mem_gnt_i in cycle 1, response in cycle 2 or later.
  - IDLE is mandatory between transactions, so the next grant comes no earlier than the cycle after the response.
- Reset mid-transaction: returns to IDLE immediately. No response is issued, and a later mem_rvalid_i is dropped.
- Writes: complete on mem_rvalid_i exactly like reads; rdata is passed through unchanged.

Test Plan:
- Single read: req0 with addr0 = 0x100, DOUBLE_WORD; mem_gnt_i in cycle 1, mem_rvalid_i in cycle 3 with rdata = 0xDEADBEEF_CAFEF00D.
  - Required: gnt0_o in cycle 0; mem_req_o = 1 in cycle 1 with addr 0x100; rvalid0_o = 1 with that rdata in cycle 3; rvalid1_o = 0 throughout.
- Contention round-robin: req0 and req1 held continuously from reset, 1-cycle memory.
  - Required: grants go 0, 1, 0, 1; each rvalid goes to the matching port.
- Backpressure: mem_gnt_i held low for 5 cycles on a port 1 write of 0x55 to addr 0x200.
  - Required: mem_req_o stays 1 with addr 0x200, wr = 1, data 0x55 unchanged until the grant; req0 asserted meanwhile receives no gnt0_o.
- Timeout: TIMEOUT_CYCLES = 8, port 0 read granted but no rvalid.
  - Required: rvalid0_o = err0_o = 1 and rdata0_o = 0 eight cycles after entering REQ, then IDLE.
  - A late mem_rvalid_i produces no response, and the next request is granted normally.
- Reset mid-RSP: assert resetn = 0 while in RSP.
  - Required: busy_o = 0 and mem_req_o = 0 immediately; mem_rvalid_i pulsed after reset release produces no rvalid0_o or rvalid1_o.
- Same-cycle rvalid and timeout: mem_rvalid_i arrives at exactly count = TIMEOUT_CYCLES.
  - Required: rvalid = 1, err = 0, rdata = mem_rdata_i.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and the memory port.
// The master modport is the arbiter's view; slave is the surrounding requesters and memory.
interface dmem_arbiter_if;
    logic        req0_i;
    logic [63:0] addr0_i;
    logic [1:0]  byte_en0_i;
    logic        wr0_i;
    logic [63:0] wr_data0_i;
    logic        gnt0_o;
    logic        rvalid0_o;
    logic [63:0] rdata0_o;
    logic        err0_o;

    logic        req1_i;
    logic [63:0] addr1_i;
    logic [1:0]  byte_en1_i;
    logic        wr1_i;
    logic [63:0] wr_data1_i;
    logic        gnt1_o;
    logic        rvalid1_o;
    logic [63:0] rdata1_o;
    logic        err1_o;

    logic        mem_req_o;
    logic [63:0] mem_addr_o;
    logic [1:0]  mem_byte_en_o;
    logic        mem_wr_o;
    logic [63:0] mem_wr_data_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [63:0] mem_rdata_i;
    logic        busy_o;

    modport master (
        input  req0_i, addr0_i, byte_en0_i, wr0_i, wr_data0_i,
        input  req1_i, addr1_i, byte_en1_i, wr1_i, wr_data1_i,
        output gnt0_o, rvalid0_o, rdata0_o, err0_o,
        output gnt1_o, rvalid1_o, rdata1_o, err1_o,
        output mem_req_o, mem_addr_o, mem_byte_en_o, mem_wr_o, mem_wr_data_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output busy_o
    );

    modport slave (
        output req0_i, addr0_i, byte_en0_i, wr0_i, wr_data0_i,
        output req1_i, addr1_i, byte_en1_i, wr1_i, wr_data1_i,
        input  gnt0_o, rvalid0_o, rdata0_o, err0_o,
        input  gnt1_o, rvalid1_o, rdata1_o, err1_o,
        input  mem_req_o, mem_addr_o, mem_byte_en_o, mem_wr_o, mem_wr_data_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  busy_o
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter for the single data-memory port: one outstanding
// transaction, response routed to its owner, optional response timeout.
module dmem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic           clk,
    input  logic           resetn,
    dmem_arbiter_if.master bus
);
    localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

    state_t      state_reg, state_next;
    logic        owner_reg;
    logic        last_winner_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [63:0] addr_reg;
    logic [1:0]  byte_en_reg;
    logic        wr_reg;
    logic [63:0] wr_data_reg;

    logic        any_req;
    logic        winner;
    logic        timeout;
    logic        rsp_ok;
    logic        resp_fire;
    logic        resp_err;
    logic [63:0] rdata_sel;
    logic [1:0]  gnt_vec;
    logic [1:0]  rvalid_vec;
    logic [1:0]  err_vec;
    logic [63:0] rdata_vec [2];

    assign any_req = bus.req0_i | bus.req1_i;
    // Under contention the port that did not win last time goes first.
    assign winner  = (bus.req0_i && bus.req1_i) ? ~last_winner_reg : bus.req1_i;

    assign timeout   = (TIMEOUT_CYCLES != 0) && (state_reg != IDLE)
                       && (cnt_reg == CNT_W'(TIMEOUT_CYCLES));
    assign rsp_ok    = (state_reg == RSP) && bus.mem_rvalid_i;
    assign resp_fire = rsp_ok | timeout;
    assign resp_err  = timeout & ~rsp_ok;
    assign rdata_sel = ((state_reg == RSP) && !resp_err) ? bus.mem_rdata_i : 64'd0;

    always_comb begin
        state_next = state_reg;
        gnt_vec    = 2'b00;
        case (state_reg)
            IDLE: begin
                if (any_req) begin
                    gnt_vec[winner] = 1'b1;
                    state_next      = REQ;
                end
            end
            REQ: begin
                if (timeout)
                    state_next = IDLE;
                else if (bus.mem_gnt_i)
                    state_next = RSP;
            end
            RSP: begin
                if (resp_fire)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg       <= IDLE;
            owner_reg       <= 1'b0;
            last_winner_reg <= 1'b1;
            cnt_reg         <= '0;
            addr_reg        <= '0;
            byte_en_reg     <= '0;
            wr_reg          <= 1'b0;
            wr_data_reg     <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && any_req) begin
                owner_reg       <= winner;
                last_winner_reg <= winner;
                cnt_reg         <= '0;
                addr_reg        <= winner ? bus.addr1_i    : bus.addr0_i;
                byte_en_reg     <= winner ? bus.byte_en1_i : bus.byte_en0_i;
                wr_reg          <= winner ? bus.wr1_i      : bus.wr0_i;
                wr_data_reg     <= winner ? bus.wr_data1_i : bus.wr_data0_i;
            end else if (state_reg != IDLE && cnt_reg != '1) begin
                // Saturate so a disabled timeout never wraps into a false match.
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign rvalid_vec[gi] = resp_fire && (owner_reg == 1'(gi));
            assign err_vec[gi]    = resp_err  && (owner_reg == 1'(gi));
            assign rdata_vec[gi]  = (owner_reg == 1'(gi)) ? rdata_sel : 64'd0;
        end
    endgenerate

    assign bus.gnt0_o    = gnt_vec[0];
    assign bus.gnt1_o    = gnt_vec[1];
    assign bus.rvalid0_o = rvalid_vec[0];
    assign bus.rvalid1_o = rvalid_vec[1];
    assign bus.err0_o    = err_vec[0];
    assign bus.err1_o    = err_vec[1];
    assign bus.rdata0_o  = rdata_vec[0];
    assign bus.rdata1_o  = rdata_vec[1];

    // A timeout in REQ withdraws the request in the same cycle it fires.
    assign bus.mem_req_o     = (state_reg == REQ) && !timeout;
    assign bus.mem_addr_o    = addr_reg;
    assign bus.mem_byte_en_o = byte_en_reg;
    assign bus.mem_wr_o      = wr_reg;
    assign bus.mem_wr_data_o = wr_data_reg;
    assign bus.busy_o        = (state_reg != IDLE);
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter: inputs change 1ns after the rising
// edge, outputs are sampled on the falling edge.
module tb_dmem_arbiter;
    logic clk;
    logic resetn;
    int   n_checks;
    int   n_errors;

    dmem_arbiter_if bus ();

    dmem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        resetn = 1'b0;
        bus.req0_i = 0; bus.addr0_i = 0; bus.byte_en0_i = 0; bus.wr0_i = 0; bus.wr_data0_i = 0;
        bus.req1_i = 0; bus.addr1_i = 0; bus.byte_en1_i = 0; bus.wr1_i = 0; bus.wr_data1_i = 0;
        bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0; bus.mem_rdata_i = 0;
        step();
        step();
        mid();
        check("reset_busy", 64'(bus.busy_o), 64'd0);
        check("reset_mem_req", 64'(bus.mem_req_o), 64'd0);
        check("reset_mem_addr", bus.mem_addr_o, 64'd0);
        check("reset_gnt0", 64'(bus.gnt0_o), 64'd0);
        step();
        resetn = 1'b1;

        // Single read on port 0
        step();
        bus.req0_i = 1; bus.addr0_i = 64'h100; bus.byte_en0_i = 2'b11; bus.wr0_i = 0;
        mid();
        check("rd_gnt0", 64'(bus.gnt0_o), 64'd1);
        check("rd_gnt1", 64'(bus.gnt1_o), 64'd0);
        step();
        bus.req0_i = 0; bus.mem_gnt_i = 1;
        mid();
        check("rd_mem_req", 64'(bus.mem_req_o), 64'd1);
        check("rd_mem_addr", bus.mem_addr_o, 64'h100);
        check("rd_mem_be", 64'(bus.mem_byte_en_o), 64'd3);
        check("rd_mem_wr", 64'(bus.mem_wr_o), 64'd0);
        step();
        bus.mem_gnt_i = 0;
        mid();
        check("rd_c2_rvalid0", 64'(bus.rvalid0_o), 64'd0);
        check("rd_c2_mem_req", 64'(bus.mem_req_o), 64'd0);
        step();
        bus.mem_rvalid_i = 1; bus.mem_rdata_i = 64'hDEADBEEF_CAFEF00D;
        mid();
        check("rd_rvalid0", 64'(bus.rvalid0_o), 64'd1);
        check("rd_rdata0", bus.rdata0_o, 64'hDEADBEEF_CAFEF00D);
        check("rd_err0", 64'(bus.err0_o), 64'd0);
        check("rd_rvalid1", 64'(bus.rvalid1_o), 64'd0);
        check("rd_rdata1", bus.rdata1_o, 64'd0);
        step();
        bus.mem_rvalid_i = 0;
        mid();
        check("rd_idle_busy", 64'(bus.busy_o), 64'd0);
        $display("txn single_read addr=0x100 done");

        // Contention from reset: grants alternate starting with port 0
        step();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        bus.req0_i = 1; bus.addr0_i = 64'hA0;
        bus.req1_i = 1; bus.addr1_i = 64'hB0;
        for (int k = 0; k < 4; k++) begin
            logic exp_port;
            exp_port = 1'(k % 2);
            mid();
            check($sformatf("rr%0d_gnt0", k), 64'(bus.gnt0_o), 64'(!exp_port));
            check($sformatf("rr%0d_gnt1", k), 64'(bus.gnt1_o), 64'(exp_port));
            step();
            bus.mem_gnt_i = 1;
            mid();
            check($sformatf("rr%0d_addr", k), bus.mem_addr_o, exp_port ? 64'hB0 : 64'hA0);
            check($sformatf("rr%0d_hold_gnt", k), 64'({bus.gnt1_o, bus.gnt0_o}), 64'd0);
            step();
            bus.mem_gnt_i = 0; bus.mem_rvalid_i = 1; bus.mem_rdata_i = 64'h1000 + 64'(k);
            mid();
            check($sformatf("rr%0d_rvalid0", k), 64'(bus.rvalid0_o), 64'(!exp_port));
            check($sformatf("rr%0d_rvalid1", k), 64'(bus.rvalid1_o), 64'(exp_port));
            step();
            bus.mem_rvalid_i = 0;
            $display("txn rr%0d port=%0d done", k, exp_port);
        end
        bus.req0_i = 0; bus.req1_i = 0;

        // Backpressure on a port 1 write while port 0 waits
        step();
        bus.req1_i = 1; bus.addr1_i = 64'h200; bus.wr1_i = 1; bus.wr_data1_i = 64'h55; bus.byte_en1_i = 2'b11;
        mid();
        check("bp_gnt1", 64'(bus.gnt1_o), 64'd1);
        step();
        bus.req1_i = 0; bus.req0_i = 1; bus.addr0_i = 64'h300; bus.wr0_i = 0;
        for (int i = 0; i < 5; i++) begin
            mid();
            check($sformatf("bp%0d_mem_req", i), 64'(bus.mem_req_o), 64'd1);
            check($sformatf("bp%0d_addr", i), bus.mem_addr_o, 64'h200);
            check($sformatf("bp%0d_wr", i), 64'(bus.mem_wr_o), 64'd1);
            check($sformatf("bp%0d_data", i), bus.mem_wr_data_o, 64'h55);
            check($sformatf("bp%0d_gnt0", i), 64'(bus.gnt0_o), 64'd0);
            step();
        end
        bus.mem_gnt_i = 1;
        mid();
        check("bp_gnt_mem_req", 64'(bus.mem_req_o), 64'd1);
        step();
        bus.mem_gnt_i = 0; bus.mem_rvalid_i = 1; bus.mem_rdata_i = 64'h77;
        mid();
        check("bp_rvalid1", 64'(bus.rvalid1_o), 64'd1);
        check("bp_rdata1", bus.rdata1_o, 64'h77);
        check("bp_rvalid0", 64'(bus.rvalid0_o), 64'd0);
        check("bp_rsp_gnt0", 64'(bus.gnt0_o), 64'd0);
        step();
        bus.mem_rvalid_i = 0;
        mid();
        check("bp_next_gnt0", 64'(bus.gnt0_o), 64'd1);
        step();
        bus.req0_i = 0; bus.mem_gnt_i = 1;
        mid();
        check("bp_next_addr", bus.mem_addr_o, 64'h300);
        step();
        bus.mem_gnt_i = 0; bus.mem_rvalid_i = 1;
        step();
        bus.mem_rvalid_i = 0;
        $display("txn backpressure write addr=0x200 done");

        // Timeout: granted by memory but no response
        bus.req0_i = 1; bus.addr0_i = 64'h400;
        mid();
        check("to_gnt0", 64'(bus.gnt0_o), 64'd1);
        step();
        bus.req0_i = 0; bus.mem_gnt_i = 1;
        step();
        bus.mem_gnt_i = 0; bus.mem_rdata_i = 64'h1234;
        for (int c = 2; c < 9; c++) begin
            mid();
            check($sformatf("to_c%0d_rvalid0", c), 64'(bus.rvalid0_o), 64'd0);
            step();
        end
        mid();
        check("to_rvalid0", 64'(bus.rvalid0_o), 64'd1);
        check("to_err0", 64'(bus.err0_o), 64'd1);
        check("to_rdata0", bus.rdata0_o, 64'd0);
        check("to_rvalid1", 64'(bus.rvalid1_o), 64'd0);
        step();
        bus.mem_rvalid_i = 1;
        mid();
        check("to_late_busy", 64'(bus.busy_o), 64'd0);
        check("to_late_rvalid0", 64'(bus.rvalid0_o), 64'd0);
        check("to_late_rvalid1", 64'(bus.rvalid1_o), 64'd0);
        step();
        bus.mem_rvalid_i = 0; bus.req0_i = 1; bus.addr0_i = 64'h500;
        mid();
        check("to_next_gnt0", 64'(bus.gnt0_o), 64'd1);
        step();
        bus.req0_i = 0; bus.mem_gnt_i = 1;
        mid();
        check("to_next_addr", bus.mem_addr_o, 64'h500);
        step();
        bus.mem_gnt_i = 0; bus.mem_rvalid_i = 1; bus.mem_rdata_i = 64'h99;
        mid();
        check("to_next_rvalid0", 64'(bus.rvalid0_o), 64'd1);
        check("to_next_err0", 64'(bus.err0_o), 64'd0);
        check("to_next_rdata0", bus.rdata0_o, 64'h99);
        step();
        bus.mem_rvalid_i = 0;
        $display("txn timeout addr=0x400 done");

        // Response arrives exactly when the counter reaches the limit
        bus.req0_i = 1; bus.addr0_i = 64'h700;
        step();
        bus.req0_i = 0; bus.mem_gnt_i = 1;
        step();
        bus.mem_gnt_i = 0;
        for (int c = 2; c < 9; c++) step();
        bus.mem_rvalid_i = 1; bus.mem_rdata_i = 64'hABCD;
        mid();
        check("tie_rvalid0", 64'(bus.rvalid0_o), 64'd1);
        check("tie_err0", 64'(bus.err0_o), 64'd0);
        check("tie_rdata0", bus.rdata0_o, 64'hABCD);
        step();
        bus.mem_rvalid_i = 0;
        mid();
        check("tie_idle_busy", 64'(bus.busy_o), 64'd0);
        $display("txn rvalid_timeout_tie addr=0x700 done");

        // Reset while waiting for the response
        step();
        bus.req1_i = 1; bus.addr1_i = 64'h600;
        mid();
        check("rst_gnt1", 64'(bus.gnt1_o), 64'd1);
        step();
        bus.req1_i = 0; bus.mem_gnt_i = 1;
        step();
        bus.mem_gnt_i = 0;
        mid();
        check("rst_busy_before", 64'(bus.busy_o), 64'd1);
        #1;
        resetn = 1'b0;
        #1;
        check("rst_busy", 64'(bus.busy_o), 64'd0);
        check("rst_mem_req", 64'(bus.mem_req_o), 64'd0);
        check("rst_mem_addr", bus.mem_addr_o, 64'd0);
        step();
        resetn = 1'b1;
        step();
        bus.mem_rvalid_i = 1; bus.mem_rdata_i = 64'h5A5A;
        mid();
        check("rst_stray_rvalid0", 64'(bus.rvalid0_o), 64'd0);
        check("rst_stray_rvalid1", 64'(bus.rvalid1_o), 64'd0);
        step();
        bus.mem_rvalid_i = 0;
        $display("txn reset_mid_rsp done");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
